// File: rtl/cpu_pkg.sv
// Shared CPU package: icache geometry default, icache FSM state encoding and
// the memory controller busy-state bit positions.
package cpu_pkg;

  localparam int ICACHE_INDEX_BITS = 6;

  // Bit positions inside the controller's 2-bit busy state.
  localparam int MC_BUSY_IF  = 1;
  localparam int MC_BUSY_MEM = 0;

  typedef enum logic [1:0] {
    IC_IDLE = 2'd0,
    IC_REQ  = 2'd1,
    IC_FILL = 2'd2
  } ic_state_e;

endpackage

// File: rtl/icache_if.sv
// Bundle of the icache's fetch-side and memory-controller-side signals.
// slave = the icache itself; master = the fetch stage plus controller around it.
interface icache_if;
  logic        rdy_in;
  logic        clear_in;
  logic        if_req_in;
  logic [31:0] if_pc_in;
  logic        icache_valid_out;
  logic [31:0] icache_instr_out;
  logic        mc_read_out;
  logic [31:0] mc_addr_out;
  logic [1:0]  mc_busy_state_in;
  logic        mc_done_in;
  logic [31:0] mc_instr_in;

  modport slave (
    input  rdy_in, clear_in, if_req_in, if_pc_in,
    input  mc_busy_state_in, mc_done_in, mc_instr_in,
    output icache_valid_out, icache_instr_out, mc_read_out, mc_addr_out
  );

  modport master (
    output rdy_in, clear_in, if_req_in, if_pc_in,
    output mc_busy_state_in, mc_done_in, mc_instr_in,
    input  icache_valid_out, icache_instr_out, mc_read_out, mc_addr_out
  );
endinterface

// File: rtl/icache_array.sv
// Storage for the direct-mapped icache: a valid vector cleared by reset plus
// tag and data RAMs. Combinational read by index, one synchronous write port.
module icache_array
  import cpu_pkg::*;
#(
  parameter int INDEX_BITS = ICACHE_INDEX_BITS
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic [INDEX_BITS-1:0]   rd_idx,
  output logic                    rd_valid,
  output logic [29-INDEX_BITS:0]  rd_tag,
  output logic [31:0]             rd_data,
  input  logic                    wr_en,
  input  logic [INDEX_BITS-1:0]   wr_idx,
  input  logic [29-INDEX_BITS:0]  wr_tag,
  input  logic [31:0]             wr_data
);
  localparam int LINES = 1 << INDEX_BITS;

  logic [LINES-1:0]        valid_q;
  logic [29-INDEX_BITS:0]  tag_mem  [LINES];
  logic [31:0]             data_mem [LINES];

  // Valid bits: cleared by reset, set when a line is filled.
  always_ff @(posedge clk_in or posedge rst_in) begin
    // NOTE: sequential state is assigned with <= so every register samples pre-edge values.
    if (rst_in) valid_q <= '0;
    else if (wr_en) valid_q[wr_idx] <= 1'b1;
  end

  // Tag/data RAM write port.
  always_ff @(posedge clk_in) begin
    // NOTE: the RAMs are deliberately not reset; the valid bits alone make stale contents harmless.
    if (wr_en) begin
      tag_mem[wr_idx]  <= wr_tag;
      data_mem[wr_idx] <= wr_data;
    end
  end

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_mem[rd_idx];
  assign rd_data  = data_mem[rd_idx];
endmodule

// File: rtl/icache.sv
// Direct-mapped, one-word-per-line instruction cache between fetch and the
// memory controller IF port. Hits answer one cycle after the request; misses
// issue a single fetch, fill the line, then answer. A flush during a miss lets
// the fill complete but suppresses the response.
// Optional: define ICACHE_PERF_EN to add hit/miss counter ports.
module icache
  import cpu_pkg::*;
#(
  parameter int INDEX_BITS = ICACHE_INDEX_BITS
) (
  input  logic        clk_in,
  input  logic        rst_in,
  icache_if.slave     bus
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0] icache_hit_cnt_out,
  output logic [31:0] icache_miss_cnt_out
`endif
);
  ic_state_e   state_q, state_d;
  logic        drop_q, drop_d;
  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic        read_q, read_d;
  logic [31:0] addr_q, addr_d;     // doubles as the latched miss pc
  logic        fill_en, lookup_hit, lookup_miss;

  logic                   rd_valid;
  logic [29-INDEX_BITS:0] rd_tag;
  logic [31:0]            rd_data;

  icache_array #(.INDEX_BITS(INDEX_BITS)) u_array (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .rd_idx  (bus.if_pc_in[INDEX_BITS+1:2]),
    .rd_valid(rd_valid),
    .rd_tag  (rd_tag),
    .rd_data (rd_data),
    .wr_en   (fill_en && bus.rdy_in),
    .wr_idx  (addr_q[INDEX_BITS+1:2]),
    .wr_tag  (addr_q[31:INDEX_BITS+2]),
    .wr_data (bus.mc_instr_in)
  );

  // Next-state and next-output logic for the IDLE/REQ/FILL controller.
  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d     = state_q;
    drop_d      = drop_q;
    valid_d     = 1'b0;
    instr_d     = instr_q;
    read_d      = read_q;
    addr_d      = addr_q;
    fill_en     = 1'b0;
    lookup_hit  = 1'b0;
    lookup_miss = 1'b0;
    case (state_q)
      IC_IDLE: begin
        // The valid_q check leaves a one-cycle gap after each response.
        if (bus.if_req_in && !valid_q && !bus.clear_in) begin
          if (rd_valid && rd_tag == bus.if_pc_in[31:INDEX_BITS+2]) begin
            lookup_hit = 1'b1;
            valid_d    = 1'b1;
            instr_d    = rd_data;
          end else begin
            lookup_miss = 1'b1;
            addr_d      = bus.if_pc_in;
            read_d      = 1'b1;
            state_d     = IC_REQ;
          end
        end
      end
      IC_REQ: begin
        // mc_done_in is ignored here: it may still be high from an older fill.
        if (bus.clear_in) drop_d = 1'b1;
        if (bus.mc_busy_state_in[MC_BUSY_IF]) state_d = IC_FILL;
      end
      IC_FILL: begin
        if (bus.mc_done_in) begin
          fill_en = 1'b1;
          read_d  = 1'b0;
          drop_d  = 1'b0;
          state_d = IC_IDLE;
          if (!drop_q && !bus.clear_in) begin
            valid_d = 1'b1;
            instr_d = bus.mc_instr_in;
          end
        end else if (bus.clear_in) begin
          drop_d = 1'b1;
        end
      end
      default: state_d = IC_IDLE;
    endcase
  end

  // State and response registers, frozen while rdy_in is low.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= IC_IDLE;
      drop_q  <= 1'b0;
      valid_q <= 1'b0;
      instr_q <= '0;
      read_q  <= 1'b0;
      addr_q  <= '0;
    end else if (bus.rdy_in) begin
      state_q <= state_d;
      drop_q  <= drop_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      read_q  <= read_d;
      addr_q  <= addr_d;
    end
  end

  assign bus.icache_valid_out = valid_q;
  assign bus.icache_instr_out = instr_q;
  assign bus.mc_read_out      = read_q;
  assign bus.mc_addr_out      = addr_q;

`ifdef ICACHE_PERF_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;

  // Accepted-lookup counters; they wrap naturally at 2^32.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (bus.rdy_in) begin
      if (lookup_hit)  hit_cnt_q  <= hit_cnt_q + 32'd1;
      if (lookup_miss) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign icache_hit_cnt_out  = hit_cnt_q;
  assign icache_miss_cnt_out = miss_cnt_q;
`endif
endmodule

// File: tb/tb_icache.sv
// Directed testbench for icache: cold miss, hit, stale done handling,
// eviction, flush during fill, rdy freeze and asynchronous reset mid-fill.
module tb_icache;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;

  icache_if bus ();

  icache dut (
    .clk_in(clk),
    .rst_in(rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle request after a one-cycle gap; on return the lookup edge has passed.
  task automatic request(input logic [31:0] pc);
    bus.if_req_in = 1'b0;
    tick();
    bus.if_req_in = 1'b1;
    bus.if_pc_in  = pc;
    tick();
    bus.if_req_in = 1'b0;
  endtask

  // Controller model: IF busy for n_busy cycles, then done with data.
  // done is dropped on the edge where busy[1] is first seen, as the controller does.
  task automatic serve_fill(input string tag, input logic [31:0] data, input int n_busy);
    bus.mc_busy_state_in = 2'b10;
    tick();
    bus.mc_done_in = 1'b0;
    for (int i = 1; i < n_busy; i++) begin
      check({tag, "_wait_valid"}, {31'd0, bus.icache_valid_out}, 32'd0);
      check({tag, "_wait_read"}, {31'd0, bus.mc_read_out}, 32'd1);
      tick();
    end
    bus.mc_done_in       = 1'b1;
    bus.mc_instr_in      = data;
    bus.mc_busy_state_in = 2'b00;
    tick();
  endtask

  initial begin
    bus.rdy_in = 1'b1;
    bus.clear_in = 1'b0;
    bus.if_req_in = 1'b0;
    bus.if_pc_in = '0;
    bus.mc_busy_state_in = 2'b00;
    bus.mc_done_in = 1'b0;
    bus.mc_instr_in = '0;

    // Reset state
    tick();
    tick();
    check("rst_valid", {31'd0, bus.icache_valid_out}, 32'd0);
    check("rst_instr", bus.icache_instr_out, 32'd0);
    check("rst_read", {31'd0, bus.mc_read_out}, 32'd0);
    check("rst_addr", bus.mc_addr_out, 32'd0);
    #2 rst = 1'b0;

    // 1. Cold miss
    request(32'h0000_1000);
    check("t1_read", {31'd0, bus.mc_read_out}, 32'd1);
    check("t1_addr", bus.mc_addr_out, 32'h0000_1000);
    check("t1_no_valid", {31'd0, bus.icache_valid_out}, 32'd0);
    serve_fill("t1", 32'h0010_0093, 5);
    check("t1_valid", {31'd0, bus.icache_valid_out}, 32'd1);
    check("t1_instr", bus.icache_instr_out, 32'h0010_0093);
    check("t1_read_off", {31'd0, bus.mc_read_out}, 32'd0);

    // 2. Hit, one cycle, single pulse (done stays sticky high from here)
    request(32'h0000_1000);
    check("t2_valid", {31'd0, bus.icache_valid_out}, 32'd1);
    check("t2_instr", bus.icache_instr_out, 32'h0010_0093);
    check("t2_read", {31'd0, bus.mc_read_out}, 32'd0);
    tick();
    check("t2_pulse", {31'd0, bus.icache_valid_out}, 32'd0);

    // 3. Stale done while data traffic delays the IF access
    request(32'h0000_2004);
    bus.mc_busy_state_in = 2'b01;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t3_stale_valid", {31'd0, bus.icache_valid_out}, 32'd0);
      check("t3_stale_read", {31'd0, bus.mc_read_out}, 32'd1);
    end
    serve_fill("t3", 32'h0020_8113, 5);
    check("t3_valid", {31'd0, bus.icache_valid_out}, 32'd1);
    check("t3_instr", bus.icache_instr_out, 32'h0020_8113);

    // 4. Same index, different tag: eviction
    request(32'h0000_1000);
    check("t4_hit", bus.icache_instr_out, 32'h0010_0093);
    request(32'h0000_1100);
    check("t4_miss_read", {31'd0, bus.mc_read_out}, 32'd1);
    check("t4_miss_addr", bus.mc_addr_out, 32'h0000_1100);
    serve_fill("t4a", 32'hAAAA_0001, 5);
    check("t4_fill_instr", bus.icache_instr_out, 32'hAAAA_0001);
    request(32'h0000_1000);
    check("t4_evicted_read", {31'd0, bus.mc_read_out}, 32'd1);
    check("t4_evicted_valid", {31'd0, bus.icache_valid_out}, 32'd0);
    serve_fill("t4b", 32'h0010_0093, 5);
    check("t4_refill_instr", bus.icache_instr_out, 32'h0010_0093);
    request(32'h0000_2004);
    check("t4_other_idx_valid", {31'd0, bus.icache_valid_out}, 32'd1);
    check("t4_other_idx_instr", bus.icache_instr_out, 32'h0020_8113);

    // 5. Flush mid-FILL: no pulse, line still written
    request(32'h0000_3008);
    bus.mc_busy_state_in = 2'b10;
    tick();
    bus.mc_done_in = 1'b0;
    tick();
    bus.clear_in = 1'b1;
    tick();
    bus.clear_in = 1'b0;
    tick();
    bus.mc_done_in = 1'b1;
    bus.mc_instr_in = 32'h0031_0193;
    bus.mc_busy_state_in = 2'b00;
    tick();
    check("t5_dropped", {31'd0, bus.icache_valid_out}, 32'd0);
    check("t5_read_off", {31'd0, bus.mc_read_out}, 32'd0);
    tick();
    check("t5_still_quiet", {31'd0, bus.icache_valid_out}, 32'd0);
    request(32'h0000_3008);
    check("t5_hit_valid", {31'd0, bus.icache_valid_out}, 32'd1);
    check("t5_hit_instr", bus.icache_instr_out, 32'h0031_0193);

    // 6a. rdy_in low for 4 cycles mid-FILL with data already presented
    request(32'h0000_400C);
    bus.mc_busy_state_in = 2'b10;
    tick();
    bus.mc_done_in = 1'b0;
    tick();
    bus.rdy_in = 1'b0;
    bus.mc_done_in = 1'b1;
    bus.mc_instr_in = 32'h0041_8213;
    bus.mc_busy_state_in = 2'b00;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t6_frozen_valid", {31'd0, bus.icache_valid_out}, 32'd0);
      check("t6_frozen_read", {31'd0, bus.mc_read_out}, 32'd1);
    end
    bus.rdy_in = 1'b1;
    tick();
    check("t6_thaw_valid", {31'd0, bus.icache_valid_out}, 32'd1);
    check("t6_thaw_instr", bus.icache_instr_out, 32'h0041_8213);

    // 6b. Asynchronous reset mid-FILL
    request(32'h0000_5010);
    bus.mc_busy_state_in = 2'b10;
    tick();
    bus.mc_done_in = 1'b0;
    tick();
    #2 rst = 1'b1;
    #1;
    check("t6_rst_read", {31'd0, bus.mc_read_out}, 32'd0);
    check("t6_rst_addr", bus.mc_addr_out, 32'd0);
    check("t6_rst_valid", {31'd0, bus.icache_valid_out}, 32'd0);
    check("t6_rst_instr", bus.icache_instr_out, 32'd0);
    bus.mc_busy_state_in = 2'b00;
    bus.mc_done_in = 1'b1;
    bus.mc_instr_in = 32'hDEAD_BEEF;
    tick();
    rst = 1'b0;
    request(32'h0000_1000);
    check("t6_cold_read", {31'd0, bus.mc_read_out}, 32'd1);
    check("t6_cold_valid", {31'd0, bus.icache_valid_out}, 32'd0);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("t6_stale_done", {31'd0, bus.icache_valid_out}, 32'd0);
    end
    serve_fill("t6", 32'h0010_0093, 5);
    check("t6_refill_valid", {31'd0, bus.icache_valid_out}, 32'd1);
    check("t6_refill_instr", bus.icache_instr_out, 32'h0010_0093);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
